sa_psum_collector: RTL
======================

// Module: sa_psum_collector
// PURPOSE
//  Downstream stage of the 3x3 weight-stationary systolic array. The array
//  emits column psums one cycle apart: col1 at t, col2 at t+1, col3 at t+2.
//  This block deskews them into one aligned 3-element row vector, buffers the
//  vectors in a FIFO and hands them to the write-back stage over valid/ready.
//  It tags tile boundaries with out_last and flags lost data with a sticky
//  overflow bit.
// PARAMETERS
//  DW         8  psum element width in bits (matches array psum_out width)
//  FIFO_DEPTH 4  vector FIFO entries; power of two, >= 2
//  TILE_ROWS  3  row vectors per tile; out_last marks the last one; >= 1
// PORTS
//  clk         in   1                   system clock, rising edge
//  rst         in   1                   async reset, ACTIVE-LOW
//  clear       in   1                   sync flush, same effect as reset
//  col_valid   in   1                   psum_in1 holds a valid row result this cycle
//  psum_in1    in   DW                  array psum_out1 (column 1)
//  psum_in2    in   DW                  array psum_out2 (column 2, +1 cycle)
//  psum_in3    in   DW                  array psum_out3 (column 3, +2 cycles)
//  out_valid   out  1                   out_data/out_last hold a FIFO head vector
//  out_ready   in   1                   consumer accepts the head this cycle
//  out_data    out  3*DW                {col3,col2,col1}; col1 at [DW-1:0]
//  out_last    out  1                   head vector is the last row of its tile
//  overflow    out  1                   sticky: a vector was dropped
//  fifo_count  out  $clog2(FIFO_DEPTH+1) current FIFO occupancy
// BEHAVIOUR
//  Reset (rst=0, async) or clear=1 at a clock edge:
//   - empties the FIFO and zeroes the deskew pipe, tile row counter and overflow
//   - outputs: out_valid=0, out_data=0, out_last=0, overflow=0, fifo_count=0
//   - clear has priority over any push or pop in the same cycle
//  Deskew:
//   - col_valid=1 at cycle t registers psum_in1 twice; psum_in2 is registered
//     once at t+1
//   - the vector {psum_in3@t+2, psum_in2@t+1, psum_in1@t} is pushed at the end
//     of cycle t+2
//   - col_valid may be asserted back-to-back; one vector per cycle is sustained
//   - psum_in* values outside their valid slot are ignored
//  Latency: col_valid at t into an empty FIFO gives out_valid=1 at t+3.
//  FIFO and handshake:
//   - pop when out_valid & out_ready
//   - out_valid is registered and deasserts only when the FIFO empties
//   - out_data/out_last hold steady while out_valid=1 and out_ready=0
//   - out_data=0 and out_last=0 whenever out_valid=0
//   - read/write pointers wrap modulo FIFO_DEPTH
//   - full with a pop in the same cycle: the push is accepted and count is unchanged
//   - full with no pop: the vector is dropped and overflow sets, holding
//     until reset or clear
//   - empty with a push: the pop side sees the vector next cycle; no bypass
//  Tile tagging:
//   - a row counter counts every deskewed vector, including dropped ones, so
//     tile alignment survives overflow
//   - the vector with counter == TILE_ROWS-1 is stored with last=1; the
//     counter then wraps to 0
//   - TILE_ROWS=1 sets last on every vector
//  Arithmetic: pure data movement; no psum modification or saturation.
//  Mid-operation reset or clear discards partial deskew state; vectors in
//  flight are lost without setting overflow.
// TESTING
//  T1 single: col_valid@t, psum_in1=0x11@t, psum_in2=0x22@t+1, psum_in3=0x33@t+2,
//     out_ready=1 -> out_valid@t+3, out_data=0x332211, out_last=0 (row 0 of 3).
//  T2 stream: 3 back-to-back rows {01,02,03},{04,05,06},{07,08,09}, ready=1 ->
//     0x030201, 0x060504, 0x090807 on consecutive cycles; out_last=1 only on 0x090807.
//  T3 backpressure: ready=0 while 4 rows are pushed -> fifo_count=4, head held;
//     then ready=1 -> 4 pops in order; a 5th push while full and ready=0 drops
//     and sets overflow=1.
//  T4 full+pop: FIFO full, ready=1 and a new push in the same cycle ->
//     fifo_count stays 4, overflow stays 0, order preserved.
//  T5 clear/reset: clear=1 with 2 vectors queued and 1 in deskew -> next cycle
//     out_valid=0, fifo_count=0, overflow=0. Repeat with rst=0 mid-cycle and
//     check outputs drop asynchronously.
//  T6 tile wrap with drop: TILE_ROWS=3, overflow drops row 2 -> row 5 is
//     still tagged last.

Source files
------------

// File: rtl/sa_psum_collector.sv
// Deskews the three skewed column psums of the 3x3 systolic array into aligned
// row vectors, tags tile boundaries, and buffers them in a valid/ready FIFO.
module sa_psum_collector #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TILE_ROWS  = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                col_valid,
    input  logic [DW-1:0]                       psum_in1,
    input  logic [DW-1:0]                       psum_in2,
    input  logic [DW-1:0]                       psum_in3,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [3*DW-1:0]                     out_data,
    output logic                                out_last,
    output logic                                overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(TILE_ROWS - 1);

    logic          r_v1, r_v2;
    logic [DW-1:0] r_p1a, r_p1b, r_p2;
    logic [RW-1:0] r_row;

    logic [3*DW:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_out_valid;
    logic          r_overflow;

    logic          w_push, w_pop, w_full, w_wr, w_drop, w_last;
    logic [3*DW-1:0] w_vec;
    logic [3*DW:0] w_head;
    logic [CW-1:0] w_count_nxt;

    // Column 1 passes two stages and column 2 one, so all three meet at t+2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_p1a <= '0;
            r_p1b <= '0;
            r_p2  <= '0;
        end else if (clear) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_p1a <= '0;
            r_p1b <= '0;
            r_p2  <= '0;
        end else begin
            r_v1 <= col_valid;
            r_v2 <= r_v1;
            if (col_valid) begin
                r_p1a <= psum_in1;
            end
            if (r_v1) begin
                r_p1b <= r_p1a;
                r_p2  <= psum_in2;
            end
        end
    end

    assign w_push = r_v2;
    assign w_vec  = {psum_in3, r_p2, r_p1b};
    assign w_last = (r_row == ROW_LAST);
    assign w_pop  = r_out_valid & out_ready;
    assign w_full = (r_count == DEPTH_C);
    assign w_wr   = w_push & (~w_full | w_pop) & ~clear;
    assign w_drop = w_push & w_full & ~w_pop;

    // Counts every deskewed vector, dropped or not, to keep tile alignment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
        end else if (clear) begin
            r_row <= '0;
        end else if (w_push) begin
            r_row <= w_last ? '0 : r_row + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {w_last, w_vec};
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clear) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            r_overflow  <= r_overflow | w_drop;
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_valid ? w_head[3*DW-1:0] : '0;
    assign out_last   = r_out_valid & w_head[3*DW];
    assign overflow   = r_overflow;
    assign fifo_count = r_count;

endmodule
